// File: rtl/mem_responder_pkg.sv
// Shared RedCPU bus definitions: responder state encoding, default bus widths
// and the access-legality rule used by the memory responder.
package mem_responder_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Out-of-range accesses and writes into the read-only low region are illegal.
    function automatic logic access_illegal(
        input int unsigned word_addr,
        input logic        is_write,
        input int unsigned depth,
        input int unsigned rom_limit
    );
        return (word_addr >= depth) || (is_write && (word_addr < rom_limit));
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word store: synchronous write port, combinational read port.
module mem_array #(
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Unimplemented words read as zero rather than indexing past the array.
    assign rdata = (32'(addr) < DEPTH) ? mem[addr] : '0;

endmodule

// File: rtl/mem_responder.sv
// RedCPU memory-side responder: accepts a CPU request, inserts wait states,
// performs the RAM access and signals completion with a one-cycle ready pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_DEPTH   = 200,
    parameter int ROM_LIMIT   = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_error,
    input  logic              err_clr
);

    generate
        if (longint'(MEM_DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
            $error("mem_responder: MEM_DEPTH exceeds the ADDR_W address space");
        end
        if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
            $error("mem_responder: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    // WAIT holds for WAIT_CYCLES cycles, so the counter starts one below that.
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        cnt_reg;
    logic [3:0]        cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mem_error_reg;

    logic              capture;
    logic              illegal;
    logic              resp_read;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    assign illegal = access_illegal(32'(addr), we, MEM_DEPTH, ROM_LIMIT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (illegal) begin
                        state_next = ST_ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                addr_reg  <= addr;
                we_reg    <= we;
                wdata_reg <= wdata;
            end
            if (resp_read) begin
                rdata_reg <= mem_rdata;
            end
            // A new illegal access outranks a simultaneous clear request.
            if (capture && illegal) begin
                mem_error_reg <= 1'b1;
            end else if (err_clr) begin
                mem_error_reg <= 1'b0;
            end
        end
    end

    assign resp_read = (state_reg == ST_RESP) && !we_reg;
    // The write lands on the edge leaving RESP; a reset on that edge aborts it.
    assign mem_wr    = (state_reg == ST_RESP) && we_reg && !reset;

    mem_array #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_wr),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    assign ready     = (state_reg == ST_RESP) || (state_reg == ST_ERR);
    assign rdata     = resp_read ? mem_rdata : rdata_reg;
    assign mem_error = mem_error_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (2 and 0 wait states) checked
// every cycle against a timing/memory model, plus hand-computed expectations.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [1:0]  err_clr_v;
    logic [1:0]  ready_v;
    logic [1:0]  err_v;
    logic [7:0]  addr_v  [2];
    logic [15:0] wdata_v [2];
    logic [15:0] rdata_v [2];

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W(8), .DATA_W(16), .MEM_DEPTH(200), .ROM_LIMIT(16), .WAIT_CYCLES(2)
    ) dut_w2 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ready(ready_v[0]), .rdata(rdata_v[0]),
        .mem_error(err_v[0]), .err_clr(err_clr_v[0])
    );

    mem_responder #(
        .ADDR_W(8), .DATA_W(16), .MEM_DEPTH(200), .ROM_LIMIT(16), .WAIT_CYCLES(0)
    ) dut_w0 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ready(ready_v[1]), .rdata(rdata_v[1]),
        .mem_error(err_v[1]), .err_clr(err_clr_v[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        checks++;
        if (act === bad) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required anything but 0x%0h", name, act, bad);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          started = 1'b0;
    int          due         [2];
    int          accept_from [2];
    bit          read_resp   [2];
    bit          exp_err     [2];
    logic [15:0] exp_rd      [2];
    bit          rd_known    [2];
    logic [15:0] last_rd     [2];
    bit          last_known  [2];
    bit          pend_w      [2];
    int          pend_at     [2];
    logic [7:0]  pend_addr   [2];
    logic [15:0] pend_data   [2];
    logic [15:0] mref        [2][256];
    bit          mknown      [2][256];

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    initial begin : model
        bit legal;
        bit set_now;
        int lat;
        for (int i = 0; i < 2; i++) begin
            due[i] = -1;
            accept_from[i] = 0;
            pend_w[i] = 1'b0;
            read_resp[i] = 1'b0;
            for (int a = 0; a < 256; a++) mknown[i][a] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    due[i] = -1;
                    accept_from[i] = cyc + 1;
                    exp_err[i] = 1'b0;
                    last_rd[i] = 16'h0000;
                    last_known[i] = 1'b1;
                    pend_w[i] = 1'b0;
                    read_resp[i] = 1'b0;
                end else begin
                    set_now = 1'b0;
                    if (pend_w[i] && cyc == pend_at[i]) begin
                        mref[i][pend_addr[i]] = pend_data[i];
                        mknown[i][pend_addr[i]] = 1'b1;
                        pend_w[i] = 1'b0;
                    end
                    if (due[i] >= 0 && cyc == due[i] + 1 && read_resp[i]) begin
                        last_rd[i] = exp_rd[i];
                        last_known[i] = rd_known[i];
                    end
                    if (req_v[i] && cyc >= accept_from[i]) begin
                        legal = (addr_v[i] < 8'd200) && !(we_v[i] && addr_v[i] < 8'd16);
                        lat = legal ? wait_of(i) : 0;
                        due[i] = cyc + lat;
                        accept_from[i] = due[i] + 2;
                        read_resp[i] = legal && !we_v[i];
                        if (!legal) begin
                            set_now = 1'b1;
                        end else if (we_v[i]) begin
                            pend_w[i] = 1'b1;
                            pend_at[i] = due[i] + 1;
                            pend_addr[i] = addr_v[i];
                            pend_data[i] = wdata_v[i];
                        end else begin
                            exp_rd[i] = mref[i][addr_v[i]];
                            rd_known[i] = mknown[i][addr_v[i]];
                        end
                    end
                    if (set_now) exp_err[i] = 1'b1;
                    else if (err_clr_v[i]) exp_err[i] = 1'b0;
                end
            end
            started = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("ready[%0d] cyc %0d", i, cyc), 32'(ready_v[i]), 32'(cyc == due[i]));
                    chk($sformatf("mem_error[%0d] cyc %0d", i, cyc), 32'(err_v[i]), 32'(exp_err[i]));
                    if (cyc == due[i] && read_resp[i]) begin
                        if (rd_known[i])
                            chk($sformatf("rdata[%0d] resp cyc %0d", i, cyc), 32'(rdata_v[i]), 32'(exp_rd[i]));
                    end else if (last_known[i]) begin
                        chk($sformatf("rdata[%0d] held cyc %0d", i, cyc), 32'(rdata_v[i]), 32'(last_rd[i]));
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int i, input bit w, input logic [7:0] a, input logic [15:0] d);
        req_v[i] = 1'b1;
        we_v[i] = w;
        addr_v[i] = a;
        wdata_v[i] = d;
    endtask

    task automatic wait_ready(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            err_clr_v[i] = 1'b0;
        end while (!ready_v[i] && n < 40);
        if (!ready_v[i]) begin
            checks++;
            failures++;
            $display("FAIL timeout[%0d]: no ready after %0d cycles, required a ready pulse", i, n);
        end
    endtask

    task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [15:0] d,
                        input bit clr, output int n, output logic [15:0] rd);
        @(negedge clk);
        issue(i, w, a, d);
        err_clr_v[i] = clr;
        wait_ready(i, n);
        rd = rdata_v[i];
        req_v[i] = 1'b0;
        $display("xfer inst=%0d we=%0d addr=%0d wdata=0x%04h -> latency=%0d rdata=0x%04h mem_error=%0d",
                 i, w, a, d, n, rd, err_v[i]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          n;
        logic [15:0] rd;
        reset = 1'b1;
        req_v = '0;
        we_v = '0;
        err_clr_v = '0;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = '0;
            wdata_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset ready", 32'(ready_v), 32'd0);
        chk("reset mem_error", 32'(err_v), 32'd0);
        chk("reset rdata0", 32'(rdata_v[0]), 32'd0);
        chk("reset rdata1", 32'(rdata_v[1]), 32'd0);

        // Two wait states: write then read back.
        xfer(0, 1'b1, 8'd20, 16'h1234, 1'b0, n, rd);
        chk("w2 write latency", 32'(n), 32'd3);
        xfer(0, 1'b0, 8'd20, 16'h0000, 1'b0, n, rd);
        chk("w2 read latency", 32'(n), 32'd3);
        chk("w2 read data", 32'(rd), 32'h1234);
        chk("w2 no error", 32'(err_v[0]), 32'd0);

        // ROM write is refused immediately and flags an error.
        xfer(0, 1'b1, 8'd5, 16'hFFFF, 1'b0, n, rd);
        chk("rom write latency", 32'(n), 32'd1);
        chk("rom write error", 32'(err_v[0]), 32'd1);
        xfer(0, 1'b0, 8'd5, 16'h0000, 1'b0, n, rd);
        chk_ne("rom unchanged", 32'(rd), 32'hFFFF);

        // Out of range read keeps the previous rdata.
        xfer(0, 1'b0, 8'd20, 16'h0000, 1'b0, n, rd);
        xfer(0, 1'b0, 8'd200, 16'h0000, 1'b0, n, rd);
        chk("oor latency", 32'(n), 32'd1);
        chk("oor rdata held", 32'(rd), 32'h1234);
        chk("oor error", 32'(err_v[0]), 32'd1);

        // err_clr together with a new illegal access: set wins.
        xfer(0, 1'b0, 8'd250, 16'h0000, 1'b1, n, rd);
        chk("clr vs set", 32'(err_v[0]), 32'd1);
        @(negedge clk);
        err_clr_v[0] = 1'b1;
        @(negedge clk);
        err_clr_v[0] = 1'b0;
        chk("clr alone", 32'(err_v[0]), 32'd0);

        // Address/data changes during WAIT are ignored.
        xfer(0, 1'b1, 8'd41, 16'h0041, 1'b0, n, rd);
        @(negedge clk);
        issue(0, 1'b1, 8'd40, 16'h5555);
        @(negedge clk);
        addr_v[0] = 8'd41;
        wdata_v[0] = 16'h6666;
        wait_ready(0, n);
        req_v[0] = 1'b0;
        chk("wait-change latency", 32'(n), 32'd2);
        xfer(0, 1'b0, 8'd40, 16'h0000, 1'b0, n, rd);
        chk("latched addr written", 32'(rd), 32'h5555);
        xfer(0, 1'b0, 8'd41, 16'h0000, 1'b0, n, rd);
        chk("new addr untouched", 32'(rd), 32'h0041);

        // Reset during WAIT aborts the write and clears the error flag.
        xfer(0, 1'b1, 8'd3, 16'h0BAD, 1'b0, n, rd);
        @(negedge clk);
        issue(0, 1'b1, 8'd30, 16'hABCD);
        @(negedge clk);
        reset = 1'b1;
        req_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        $display("reset asserted during WAIT of write addr=30");
        chk("reset abort ready", 32'(ready_v[0]), 32'd0);
        chk("reset clears error", 32'(err_v[0]), 32'd0);
        chk("reset clears rdata", 32'(rdata_v[0]), 32'd0);
        xfer(0, 1'b0, 8'd30, 16'h0000, 1'b0, n, rd);
        chk("post-reset latency", 32'(n), 32'd3);
        chk_ne("aborted write", 32'(rd), 32'hABCD);

        // Zero wait states, including back-to-back reads.
        xfer(1, 1'b1, 8'd20, 16'h00AA, 1'b0, n, rd);
        chk("w0 write latency", 32'(n), 32'd1);
        @(negedge clk);
        issue(1, 1'b0, 8'd20, 16'h0000);
        wait_ready(1, n);
        chk("w0 read latency", 32'(n), 32'd1);
        chk("w0 read data", 32'(rdata_v[1]), 32'h00AA);
        wait_ready(1, n);
        chk("w0 back-to-back spacing", 32'(n), 32'd2);
        chk("w0 b2b data", 32'(rdata_v[1]), 32'h00AA);
        req_v[1] = 1'b0;
        $display("back-to-back inst=1 addr=20 spacing=%0d rdata=0x%04h", n, rdata_v[1]);
        xfer(1, 1'b1, 8'd15, 16'hFFFF, 1'b0, n, rd);
        chk("w0 rom latency", 32'(n), 32'd1);
        chk("w0 rom error", 32'(err_v[1]), 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
